// File: rtl/bsg_clk_calib_pkg.sv
// bsg_clk_calib_pkg: shared states, compare results and defaults for oscillator calibration
package bsg_clk_calib_pkg;
    localparam int tap_width_gp     = 5;
    localparam int count_width_gp   = 16;
    localparam int window_width_gp  = 16;
    localparam int settle_cycles_gp = 8;
    localparam int sync_cycles_gp   = 4;

    typedef enum logic [2:0] {S_IDLE, S_MEAS, S_DECIDE, S_LOCKED, S_ERR} ctrl_state_e;
    typedef enum logic [2:0] {M_IDLE, M_APPLY, M_CLEAR, M_COUNT, M_FREEZE, M_SAMPLE} meas_state_e;
    typedef enum logic [1:0] {CMP_IN, CMP_FAST, CMP_SLOW} cmp_e;
endpackage

// File: rtl/bsg_clk_calib_meas_seq.sv
// bsg_clk_calib_meas_seq: settle, monitor clear, count window, freeze and sample of one measurement
module bsg_clk_calib_meas_seq
    import bsg_clk_calib_pkg::*;
#(
    parameter int count_width_p   = count_width_gp,
    parameter int window_width_p  = window_width_gp,
    parameter int settle_cycles_p = settle_cycles_gp,
    parameter int sync_cycles_p   = sync_cycles_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      go_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic [count_width_p-1:0]  div_count_i,
    output logic                      mon_reset_o,
    output logic                      mon_en_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  count_o
);
    localparam logic [window_width_p-1:0] settle_lp = window_width_p'(settle_cycles_p - 1);
    localparam logic [window_width_p-1:0] sync_lp   = window_width_p'(sync_cycles_p - 1);

    meas_state_e state_q, state_n;
    logic [window_width_p-1:0] cnt_q, cnt_n;
    logic [count_width_p-1:0] count_q, count_n;
    logic last;

    assign last = cnt_q == '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= M_IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            count_q <= count_n;
        end
    end

    // cnt_q holds remaining cycles minus one of the current phase
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q - 1'b1;
        count_n = count_q;
        case (state_q)
            M_IDLE: begin
                cnt_n = settle_lp;
                if (go_i) state_n = M_APPLY;
            end
            M_APPLY: if (last) begin
                state_n = M_CLEAR;
                cnt_n   = sync_lp;
            end
            M_CLEAR: if (last) begin
                state_n = M_COUNT;
                cnt_n   = (window_i == '0) ? '0 : window_i - 1'b1;
            end
            M_COUNT: if (last) begin
                state_n = M_FREEZE;
                cnt_n   = sync_lp;
            end
            M_FREEZE: if (last) state_n = M_SAMPLE;
            M_SAMPLE: begin
                count_n = div_count_i;
                state_n = M_IDLE;
            end
            default: state_n = M_IDLE;
        endcase
    end

    assign mon_reset_o = state_q == M_IDLE || state_q == M_APPLY || state_q == M_CLEAR;
    assign mon_en_o    = state_q == M_COUNT;
    assign done_o      = state_q == M_SAMPLE;
    assign count_o     = count_q;
endmodule

// File: rtl/bsg_clk_osc_calib_ctrl.sv
// bsg_clk_osc_calib_ctrl: SAR search and drift tracking of the oscillator tap against a monitored count
module bsg_clk_osc_calib_ctrl
    import bsg_clk_calib_pkg::*;
#(
    parameter int tap_width_p     = tap_width_gp,
    parameter int count_width_p   = count_width_gp,
    parameter int window_width_p  = window_width_gp,
    parameter int settle_cycles_p = settle_cycles_gp,
    parameter int sync_cycles_p   = sync_cycles_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [window_width_p-1:0] window_i,
    input  logic [count_width_p-1:0]  target_i,
    input  logic [count_width_p-1:0]  tol_i,
    input  logic                      track_en_i,
    input  logic [count_width_p-1:0]  div_count_i,
    output logic                      mon_reset_o,
    output logic                      mon_en_o,
    output logic [tap_width_p-1:0]    tap_o,
    output logic                      tap_v_o,
    output logic                      busy_o,
    output logic                      lock_o,
    output logic                      err_o,
    output logic [count_width_p-1:0]  meas_count_o
);
    localparam int k_width_lp = (tap_width_p > 1) ? $clog2(tap_width_p) : 1;
    localparam logic [tap_width_p-1:0] tap_mid_lp = {1'b1, {(tap_width_p-1){1'b0}}};
    localparam logic [k_width_lp-1:0] k_top_lp = k_width_lp'(tap_width_p - 1);

    ctrl_state_e state_q, state_n;
    logic [tap_width_p-1:0] tap_q, tap_n, tap_set;
    logic [k_width_lp-1:0] k_q, k_n;
    logic final_q, final_n, trk_q, trk_n, lock_q, lock_n, err_q, err_n, tap_v_q;
    logic go, init, done;
    logic [count_width_p:0] hi_sum, lo_dif;
    logic [count_width_p-1:0] hi, lo, meas;
    cmp_e cmp;

    bsg_clk_calib_meas_seq #(
        .count_width_p  (count_width_p),
        .window_width_p (window_width_p),
        .settle_cycles_p(settle_cycles_p),
        .sync_cycles_p  (sync_cycles_p)
    ) seq (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .go_i       (go),
        .window_i   (window_i),
        .div_count_i(div_count_i),
        .mon_reset_o(mon_reset_o),
        .mon_en_o   (mon_en_o),
        .done_o     (done),
        .count_o    (meas)
    );

    // bounds are widened one bit so the tolerance band saturates instead of wrapping
    assign hi_sum = {1'b0, target_i} + {1'b0, tol_i};
    assign lo_dif = {1'b0, target_i} - {1'b0, tol_i};
    assign hi  = hi_sum[count_width_p] ? '1 : hi_sum[count_width_p-1:0];
    assign lo  = lo_dif[count_width_p] ? '0 : lo_dif[count_width_p-1:0];
    assign cmp = (meas > hi) ? CMP_FAST : (meas < lo) ? CMP_SLOW : CMP_IN;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            tap_q   <= tap_mid_lp;
            k_q     <= k_top_lp;
            final_q <= 1'b0;
            trk_q   <= 1'b0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            tap_v_q <= 1'b0;
        end else begin
            state_q <= state_n;
            tap_q   <= tap_n;
            k_q     <= k_n;
            final_q <= final_n;
            trk_q   <= trk_n;
            lock_q  <= lock_n;
            err_q   <= err_n;
            tap_v_q <= init || tap_n != tap_q;
        end
    end

    always_comb begin
        state_n = state_q;
        tap_n   = tap_q;
        k_n     = k_q;
        final_n = final_q;
        trk_n   = trk_q;
        lock_n  = lock_q;
        err_n   = err_q;
        go      = 1'b0;
        init    = 1'b0;
        tap_set = tap_q;
        tap_set[k_q] = cmp == CMP_FAST;
        case (state_q)
            S_IDLE, S_ERR: init = start_i;
            S_LOCKED: begin
                init    = start_i;
                go      = !start_i && track_en_i;
                state_n = go ? S_MEAS : S_LOCKED;
            end
            S_MEAS: if (done) state_n = S_DECIDE;
            S_DECIDE: begin
                if (cmp == CMP_IN) begin
                    state_n = S_LOCKED;
                    lock_n  = 1'b1;
                    trk_n   = 1'b1;
                end else if (trk_q) begin
                    if (cmp == CMP_FAST ? tap_q == '1 : tap_q == '0) begin
                        state_n = S_ERR;
                        err_n   = 1'b1;
                        lock_n  = 1'b0;
                    end else begin
                        tap_n   = (cmp == CMP_FAST) ? tap_q + 1'b1 : tap_q - 1'b1;
                        lock_n  = 1'b0;
                        go      = track_en_i;
                        state_n = track_en_i ? S_MEAS : S_LOCKED;
                    end
                end else if (!final_q && k_q != '0) begin
                    tap_n = tap_set;
                    tap_n[k_q - 1'b1] = 1'b1;
                    k_n     = k_q - 1'b1;
                    go      = 1'b1;
                    state_n = S_MEAS;
                end else if (!final_q && tap_set != tap_q) begin
                    tap_n   = tap_set;
                    final_n = 1'b1;
                    go      = 1'b1;
                    state_n = S_MEAS;
                end else begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (init) begin
            tap_n   = tap_mid_lp;
            k_n     = k_top_lp;
            final_n = 1'b0;
            trk_n   = 1'b0;
            lock_n  = 1'b0;
            err_n   = 1'b0;
            go      = 1'b1;
            state_n = S_MEAS;
        end
    end

    assign tap_o   = tap_q;
    assign tap_v_o = tap_v_q;
    assign lock_o  = lock_q;
    assign err_o   = err_q;
    assign busy_o  = state_q == S_MEAS || state_q == S_DECIDE || (state_q == S_LOCKED && track_en_i);
    assign meas_count_o = meas;
endmodule

// File: tb/tb_bsg_clk_osc_calib_ctrl.sv
// tb_bsg_clk_osc_calib_ctrl: scoreboard bench driving a linear tap-to-count oscillator model
module tb_bsg_clk_osc_calib_ctrl;
    logic clk = 1'b0;
    logic reset_i = 1'b1, start_i = 1'b0, track_en_i = 1'b0;
    logic [15:0] window_i = 16'd100, target_i = '0, tol_i = '0, div_count_i;
    logic mon_reset_o, mon_en_o, tap_v_o, busy_o, lock_o, err_o;
    logic [4:0] tap_o;
    logic [15:0] meas_count_o;

    int checks = 0, passes = 0;
    int exp_q[$];
    int cyc = 0, last_pulse = -1, en_run = 0, overlap = 0, shift = 0;
    bit force_fast = 1'b0;

    always #5 clk = ~clk;

    always_comb div_count_i = force_fast ? 16'd5000 : 16'(2000 + shift - 50 * int'(tap_o));

    bsg_clk_osc_calib_ctrl dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .window_i    (window_i),
        .target_i    (target_i),
        .tol_i       (tol_i),
        .track_en_i  (track_en_i),
        .div_count_i (div_count_i),
        .mon_reset_o (mon_reset_o),
        .mon_en_o    (mon_en_o),
        .tap_o       (tap_o),
        .tap_v_o     (tap_v_o),
        .busy_o      (busy_o),
        .lock_o      (lock_o),
        .err_o       (err_o),
        .meas_count_o(meas_count_o)
    );

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // each tap_v_o pulse pops the next expected tap; consecutive pulses are one sequence apart
    always @(negedge clk) begin
        cyc++;
        if (reset_i) en_run = 0;
        else if (mon_en_o) en_run++;
        else if (en_run != 0) begin
            check("en_width", en_run, (window_i == 0) ? 1 : int'(window_i));
            en_run = 0;
        end
        if (mon_reset_o && mon_en_o) overlap++;
        if (tap_v_o) begin
            if (exp_q.size() == 0) check("tap_v_extra", 1, 0);
            else check("tap_seq", int'(tap_o), exp_q.pop_front());
            if (last_pulse >= 0)
                check("seq_latency", cyc - last_pulse, 8 + 2 * 4 + ((window_i == 0) ? 1 : int'(window_i)) + 2);
            last_pulse = cyc;
        end
    end

    task automatic start_search(int tgt, int tl);
        target_i   = 16'(tgt);
        tol_i      = 16'(tl);
        last_pulse = -1;
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        repeat (2) @(negedge clk);
        while (busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy_o), 0);
    endtask

    task automatic wait_lock(string tag, logic v);
        int n = 0;
        while (lock_o !== v && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(lock_o), int'(v));
    endtask

    task automatic check_result(string tag, int lk, int er, int tp, int mc);
        check({tag, "_lock"}, int'(lock_o), lk);
        check({tag, "_err"}, int'(err_o), er);
        check({tag, "_tap"}, int'(tap_o), tp);
        check({tag, "_meas"}, int'(meas_count_o), mc);
        check({tag, "_taps_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_tap"}, int'(tap_o), 16);
        check({tag, "_mon_reset"}, int'(mon_reset_o), 1);
        check({tag, "_mon_en"}, int'(mon_en_o), 0);
        check({tag, "_tap_v"}, int'(tap_v_o), 0);
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_lock"}, int'(lock_o), 0);
        check({tag, "_err"}, int'(err_o), 0);
        check({tag, "_meas"}, int'(meas_count_o), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset("rst");
        reset_i = 1'b0;
        @(negedge clk);

        // 1250+-20: 16 slow, 8/12/14 fast, 15 in band; a start pulse mid-search must be ignored
        exp_q = '{16, 8, 12, 14, 15};
        start_search(1250, 20);
        repeat (60) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle("sar_idle");
        check_result("sar", 1, 0, 15, 1250);

        // drift +60: tap 15 reads 1310 (fast), tap 16 reads 1260 (in band)
        last_pulse = -1;
        exp_q.push_back(16);
        shift      = 60;
        track_en_i = 1'b1;
        wait_lock("trk_drop", 1'b0);
        wait_lock("trk_relock", 1'b1);
        check("trk_tap", int'(tap_o), 16);
        check("trk_meas", int'(meas_count_o), 1260);
        track_en_i = 1'b0;
        wait_idle("trk_idle");
        check("trk_hold_lock", int'(lock_o), 1);
        shift = 0;

        // 1275+-10: tap 15 slow at the last bit, final pass at 14 is fast -> error
        exp_q = '{16, 8, 12, 14, 15, 14};
        start_search(1275, 10);
        wait_idle("final_idle");
        check_result("final", 0, 1, 14, 1300);

        // 100+-5 is unreachable: every tap is fast, restart from error
        exp_q = '{16, 24, 28, 30, 31};
        start_search(100, 5);
        wait_idle("nolock_idle");
        check_result("nolock", 0, 1, 31, 450);

        // lock at the slowest tap, then an always-fast oscillator saturates tracking
        exp_q = '{16, 24, 28, 30, 31};
        start_search(450, 5);
        wait_idle("max_idle");
        check_result("max", 1, 0, 31, 450);
        last_pulse = -1;
        force_fast = 1'b1;
        track_en_i = 1'b1;
        n = 0;
        while (!err_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_result("sat", 0, 1, 31, 5000);
        track_en_i = 1'b0;
        force_fast = 1'b0;
        @(negedge clk);
        check("sat_busy", int'(busy_o), 0);

        // zero-length window still counts for one cycle
        window_i = 16'd0;
        exp_q = '{16, 8, 12, 14, 15};
        start_search(1250, 20);
        wait_idle("win0_idle");
        check_result("win0", 1, 0, 15, 1250);

        // reset in the middle of the second count window
        window_i = 16'd100;
        exp_q = '{16, 8};
        start_search(1250, 20);
        n = 0;
        while (!(tap_o == 5'd8 && mon_en_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_count", int'(mon_en_o), 1);
        reset_i = 1'b1;
        @(negedge clk);
        check_reset("mid_rst");
        @(negedge clk);
        reset_i = 1'b0;
        exp_q.delete();
        last_pulse = -1;
        repeat (3) @(negedge clk);
        check("overlap", overlap, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
